// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronised rising edges of sig_in over GATE_CYCLES+1 clocks, publishes packed BCD.
// Build option: define FREQ_METER_SAT_EN to saturate the count at all-nines on overflow instead of wrapping.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int DIGITS      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sig_in,
    output logic [4*DIGITS-1:0]   freq_bcd,
    output logic                  result_valid,
    output logic                  overflow,
    output logic                  gate_active
);

    localparam int                 BCD_W      = 4 * DIGITS;
    localparam int                 TIMER_W    = $clog2(GATE_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);

`ifdef FREQ_METER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic               sigSync_p0;
    logic               sigSync_p1;
    logic               sigSync_p2;
    logic               sigEdge;
    logic [TIMER_W-1:0] gateTimer;
    logic [BCD_W-1:0]   bcdCnt;
    logic               ovfSticky;
    logic               isIdle;
    logic               isLatch;

    // A digit at or above 9 always rolls to 0, so no stored digit can ever exceed 9.
    function automatic logic [BCD_W-1:0] bcdInc(input logic [BCD_W-1:0] val);
        logic carry;
        bcdInc = val;
        carry  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (val[4*i +: 4] >= 4'd9) begin
                    bcdInc[4*i +: 4] = 4'd0;
                end else begin
                    bcdInc[4*i +: 4] = val[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic bcdAllNines(input logic [BCD_W-1:0] val);
        bcdAllNines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (val[4*i +: 4] != 4'd9) begin
                bcdAllNines = 1'b0;
            end
        end
    endfunction

    // Synchroniser stages p0/p1, p2 holds the previous sample for edge detect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sigSync_p0 <= 1'b0;
            sigSync_p1 <= 1'b0;
            sigSync_p2 <= 1'b0;
        end else begin
            sigSync_p0 <= sig_in;
            sigSync_p1 <= sigSync_p0;
            sigSync_p2 <= sigSync_p1;
        end
    end

    assign sigEdge = sigSync_p1 & ~sigSync_p2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (enable) stateNext = GATE;
            end
            GATE: begin
                if (!enable)                      stateNext = IDLE;
                else if (gateTimer == TIMER_LAST) stateNext = LATCH;
            end
            LATCH: begin
                stateNext = enable ? GATE : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        gate_active = 1'b0;
        isIdle      = 1'b0;
        isLatch     = 1'b0;
        case (state)
            IDLE:    isIdle      = 1'b1;
            GATE:    gate_active = 1'b1;
            LATCH:   isLatch     = 1'b1;
            default: isIdle      = 1'b1;
        endcase
    end

    // Counting and result register; an edge seen during LATCH seeds the next window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gateTimer    <= '0;
            bcdCnt       <= '0;
            ovfSticky    <= 1'b0;
            freq_bcd     <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= isLatch;
            if (isIdle) begin
                gateTimer <= '0;
                bcdCnt    <= '0;
                ovfSticky <= 1'b0;
            end else if (isLatch) begin
                freq_bcd  <= bcdCnt;
                overflow  <= ovfSticky;
                bcdCnt    <= {{(BCD_W-1){1'b0}}, sigEdge};
                gateTimer <= '0;
                ovfSticky <= 1'b0;
            end else begin
                gateTimer <= gateTimer + 1'b1;
                if (sigEdge) begin
                    if (bcdAllNines(bcdCnt)) begin
                        ovfSticky <= 1'b1;
                        if (!SAT_EN) bcdCnt <= bcdInc(bcdCnt);
                    end else begin
                        bcdCnt <= bcdInc(bcdCnt);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: three instances (short gate, 2-digit overflow, long gate) checked against a windowed edge-count scoreboard.
module tb_freq_meter;

    logic        clock  = 1'b0;
    logic        reset  = 1'b0;
    logic        sig_in = 1'b0;
    logic        en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
    logic [15:0] fb0;
    logic [7:0]  fb1;
    logic [15:0] fb2;
    logic        rv0, rv1, rv2;
    logic        ov0, ov1, ov2;
    logic        ga0, ga1, ga2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int genN0  = 0;
    int genP   = 4;
    int genEnd = 0;

    typedef struct {
        int          id;
        int          cyc;
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;
    exp_t expQ[$];

    freq_meter #(.GATE_CYCLES(100), .DIGITS(4)) u0 (
        .clock(clock), .reset(reset), .enable(en0), .sig_in(sig_in),
        .freq_bcd(fb0), .result_valid(rv0), .overflow(ov0), .gate_active(ga0));
    freq_meter #(.GATE_CYCLES(1000), .DIGITS(2)) u1 (
        .clock(clock), .reset(reset), .enable(en1), .sig_in(sig_in),
        .freq_bcd(fb1), .result_valid(rv1), .overflow(ov1), .gate_active(ga1));
    freq_meter #(.GATE_CYCLES(2000), .DIGITS(4)) u2 (
        .clock(clock), .reset(reset), .enable(en2), .sig_in(sig_in),
        .freq_bcd(fb2), .result_valid(rv2), .overflow(ov2), .gate_active(ga2));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Square wave, first sampled high at posedge genN0, stopping before posedge genEnd.
    function automatic logic genValue(int n);
        if (genEnd > genN0 && n >= genN0 && n < genEnd)
            return ((n - genN0) % genP) < (genP / 2);
        return 1'b0;
    endfunction

    always @(negedge clock) sig_in = genValue(cyc + 1);

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] toBcd(int cnt, int d);
        int          maxv;
        int          v;
        logic [31:0] r;
        maxv = 1;
        for (int i = 0; i < d; i++) maxv *= 10;
        maxv -= 1;
        if (cnt > maxv) begin
`ifdef FREQ_METER_SAT_EN
            v = maxv;
`else
            v = cnt % (maxv + 1);
`endif
        end else begin
            v = cnt;
        end
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic digitsOk(logic [31:0] v);
        for (int i = 0; i < 8; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Edge sampled high at posedge n increments the counter at posedge n+2; window 0 spans
    // posedges m+1..m+g, later windows start on the previous LATCH posedge and span g+1 posedges.
    task automatic planWindows(int id, int m, int g, int d, int nWin);
        exp_t e;
        int   lo, hi, cnt, maxv;
        maxv = 1;
        for (int i = 0; i < d; i++) maxv *= 10;
        maxv -= 1;
        for (int w = 0; w < nWin; w++) begin
            lo  = (w == 0) ? m + 1 : m + w * (g + 1);
            hi  = m + w * (g + 1) + g;
            cnt = 0;
            for (int n = genN0; n < genEnd; n += genP)
                if (n + 2 >= lo && n + 2 <= hi) cnt++;
            e.id  = id;
            e.cyc = m + (w + 1) * (g + 1);
            e.ovf = (cnt > maxv);
            e.bcd = toBcd(cnt, d);
            expQ.push_back(e);
        end
    endtask

    task automatic checkResult(int id, logic [31:0] bcd, logic ovf);
        exp_t e;
        checks++;
        assert (expQ.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_valid id=%0d observed=%h expected=none", id, bcd);
        end
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            chk("result_id", 32'(id), 32'(e.id));
            chk("result_cycle", 32'(cyc), 32'(e.cyc));
            chk("result_bcd", bcd, e.bcd);
            chk("result_ovf", 32'(ovf), 32'(e.ovf));
            chk("result_digits_le9", 32'(digitsOk(bcd)), 32'd1);
        end
    endtask

    always @(negedge clock) begin
        if (rv0) checkResult(0, 32'(fb0), ov0);
        if (rv1) checkResult(1, 32'(fb1), ov1);
        if (rv2) checkResult(2, 32'(fb2), ov2);
    end

    task automatic cycles(int k);
        repeat (k) @(posedge clock);
        #2;
    endtask

    task automatic waitDrain(int maxc);
        int k;
        k = 0;
        while (expQ.size() != 0 && k < maxc) begin
            cycles(1);
            k++;
        end
        checks++;
        assert (expQ.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout observed_pending=%0d expected=0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        int          m;
        logic [31:0] lastBcd;

        // Reset and idle
        cycles(3);
        chk("rst_fb0", 32'(fb0), 32'h0);
        chk("rst_rv0", 32'(rv0), 32'h0);
        chk("rst_ov0", 32'(ov0), 32'h0);
        chk("rst_ga0", 32'(ga0), 32'h0);
        chk("rst_fb1", 32'(fb1), 32'h0);
        chk("rst_fb2", 32'(fb2), 32'h0);
        reset = 1'b1;
        cycles(500);
        chk("idle_fb0", 32'(fb0), 32'h0);
        chk("idle_ga0", 32'(ga0), 32'h0);
        chk("idle_ga2", 32'(ga2), 32'h0);

        // Periodic input, period 4, aligned to the window, five back-to-back windows
        m = cyc + 1;
        en0 = 1'b1; genN0 = m; genP = 4; genEnd = m + 6000;
        planWindows(0, m, 100, 4, 5);
        lastBcd = expQ[$].bcd;
        cycles(2);
        chk("run_ga0", 32'(ga0), 32'h1);
        waitDrain(600);

        // Enable abort mid-window: no result, previous value held
        en0 = 1'b0; genEnd = 0;
        cycles(5);
        chk("abort_hold_fb0", 32'(fb0), lastBcd);
        chk("abort_ga0", 32'(ga0), 32'h0);
        cycles(200);
        chk("abort_hold2_fb0", 32'(fb0), lastBcd);

        // Edge detected exactly in the LATCH cycle belongs to the next window
        m = cyc + 1;
        en0 = 1'b1; genN0 = m + 95; genP = 4; genEnd = m + 107;
        planWindows(0, m, 100, 4, 2);
        waitDrain(300);
        en0 = 1'b0; genEnd = 0;
        cycles(5);

        // BCD carry into the hundreds digit: 100 edges
        m = cyc + 1;
        en2 = 1'b1; genN0 = m; genP = 20; genEnd = m + 2500;
        planWindows(2, m, 2000, 4, 1);
        waitDrain(2200);
        en2 = 1'b0; genEnd = 0;
        cycles(5);
        chk("carry_hold_fb2", 32'(fb2), 32'h0100);

        // Overflow on the 2-digit instance: 250 edges
        m = cyc + 1;
        en1 = 1'b1; genN0 = m; genP = 4; genEnd = m + 1200;
        planWindows(1, m, 1000, 2, 1);
        waitDrain(1200);
        en1 = 1'b0; genEnd = 0;
        cycles(5);
        chk("ovf_flag_u1", 32'(ov1), 32'h1);

        // Reset asserted mid-window
        m = cyc + 1;
        en0 = 1'b1; genN0 = m; genP = 4; genEnd = m + 1000;
        cycles(50);
        reset = 1'b0;
        #1;
        chk("rstabort_fb0", 32'(fb0), 32'h0);
        chk("rstabort_ga0", 32'(ga0), 32'h0);
        chk("rstabort_rv0", 32'(rv0), 32'h0);
        chk("rstabort_fb1", 32'(fb1), 32'h0);
        chk("rstabort_ov1", 32'(ov1), 32'h0);
        en0 = 1'b0; genEnd = 0;
        cycles(3);
        reset = 1'b1;
        cycles(300);
        chk("rstabort_idle_ga0", 32'(ga0), 32'h0);
        chk("rstabort_idle_fb0", 32'(fb0), 32'h0);

        // Recovery: first result one full window after enable
        m = cyc + 1;
        en0 = 1'b1; genN0 = m; genP = 4; genEnd = m + 500;
        planWindows(0, m, 100, 4, 1);
        waitDrain(200);
        en0 = 1'b0; genEnd = 0;
        cycles(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
